alu_issue_sequencer: RTL and testbench

// Issue-side controller for the ALU_enhanced datapath. It accepts one decoded ALU instruction per

---
 rtl/alu_issue_sequencer_pkg.sv | 56 +++++
 rtl/alu_issue_sequencer_if.sv | 38 +++
 rtl/alu_issue_sequencer_cond_check.sv | 33 +++
 rtl/alu_issue_sequencer.sv | 98 +++++++++
 tb/tb_alu_issue_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_sequencer_pkg.sv
// Shared types and Fnc_SEL encoding for the ALU issue sequencer.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_ADC, OP_SUB, OP_SBC, OP_RSB, OP_AND, OP_BIC, OP_ORR,
    OP_EOR, OP_MOV, OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_CMP, OP_TST
  } opcode_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

  localparam logic [2:0] MUX_ADD  = 3'b000;
  localparam logic [2:0] MUX_AND  = 3'b001;
  localparam logic [2:0] MUX_ORR  = 3'b010;
  localparam logic [2:0] MUX_EOR  = 3'b011;
  localparam logic [2:0] MUX_SHR  = 3'b100;
  localparam logic [2:0] MUX_LSL  = 3'b101;
  localparam logic [2:0] MUX_MOV  = 3'b110;
  localparam logic [1:0] SH_LSR   = 2'b00;
  localparam logic [1:0] SH_ASR   = 2'b01;
  localparam logic [1:0] SH_ROR   = 2'b10;
  localparam int         FNC_CIN  = 5;
  localparam int         FNC_RSB  = 6;
  localparam int         FNC_SUB  = 7;
  localparam int         FNC_INV  = 8;
  localparam logic [8:0] FNC_IDLE = 9'h007;

  // carry_i is the architectural C at accept time (ADC/SBC carry-in).
  function automatic logic [8:0] fnc_encode(opcode_e op, logic carry_i);
    logic [8:0] f;
    f = '0;
    case (op)
      OP_ADD: ;
      OP_ADC: f[FNC_CIN] = carry_i;
      OP_SUB, OP_CMP: begin f[FNC_SUB] = 1'b1; f[FNC_CIN] = 1'b1; end
      OP_SBC: begin f[FNC_SUB] = 1'b1; f[FNC_CIN] = carry_i; end
      OP_RSB: begin f[FNC_RSB] = 1'b1; f[FNC_CIN] = 1'b1; end
      OP_AND, OP_TST: f[2:0] = MUX_AND;
      OP_BIC: begin f[2:0] = MUX_AND; f[FNC_INV] = 1'b1; end
      OP_ORR: f[2:0] = MUX_ORR;
      OP_EOR: f[2:0] = MUX_EOR;
      OP_MOV: f[2:0] = MUX_MOV;
      OP_LSL: f[2:0] = MUX_LSL;
      OP_LSR: begin f[2:0] = MUX_SHR; f[4:3] = SH_LSR; end
      OP_ASR: begin f[2:0] = MUX_SHR; f[4:3] = SH_ASR; end
      OP_ROR: begin f[2:0] = MUX_SHR; f[4:3] = SH_ROR; end
      default: f = FNC_IDLE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_issue_sequencer_if.sv
// Decode-side, ALU-side and writeback-side signals of the issue sequencer.
interface alu_issue_sequencer_if #(parameter int NR_OF_BITS = 32);
  import alu_ctrl_pkg::*;

  logic                  In_Valid;
  logic                  In_Ready;
  opcode_e               In_Opcode;
  cond_e                 In_Cond;
  logic                  In_SetFlags;
  logic [3:0]            In_Rd;
  logic [NR_OF_BITS-1:0] In_Op1;
  logic [NR_OF_BITS-1:0] In_Op2;
  logic [8:0]            Fnc_SEL;
  logic [NR_OF_BITS-1:0] Op1;
  logic [NR_OF_BITS-1:0] Op2;
  logic [NR_OF_BITS-1:0] RESULT;
  logic [3:0]            Flag_Out;
  logic                  Out_Valid;
  logic                  Out_Ready;
  logic [NR_OF_BITS-1:0] Out_Result;
  logic [3:0]            Out_Rd;
  logic                  Out_WbEn;
  logic [3:0]            Status_NZCV;

  modport slave (
    input  In_Valid, In_Opcode, In_Cond, In_SetFlags, In_Rd, In_Op1, In_Op2,
           RESULT, Flag_Out, Out_Ready,
    output In_Ready, Fnc_SEL, Op1, Op2, Out_Valid, Out_Result, Out_Rd, Out_WbEn,
           Status_NZCV
  );

  modport master (
    output In_Valid, In_Opcode, In_Cond, In_SetFlags, In_Rd, In_Op1, In_Op2,
           RESULT, Flag_Out, Out_Ready,
    input  In_Ready, Fnc_SEL, Op1, Op2, Out_Valid, Out_Result, Out_Rd, Out_WbEn,
           Status_NZCV
  );
endinterface

// File: rtl/alu_issue_sequencer_cond_check.sv
// Condition-code evaluation against NZCV ({N,Z,C,V}).
module alu_cond_check
  import alu_ctrl_pkg::*;
(
  input  cond_e      cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv_i;

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_issue_sequencer.sv
// Issue controller: accepts one ALU instruction, drives the ALU for EXEC_CYCLES,
// captures result/flags, and holds a writeback record until it is taken.
module alu_issue_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int         NR_OF_BITS   = 32,
  parameter int         EXEC_CYCLES  = 1,
  parameter logic [3:0] STATUS_RESET = 4'h0
)(
  input  logic                  Clock,
  input  logic                  Reset_n,
  alu_issue_sequencer_if.slave  bus
);
  localparam logic [1:0] CNT_INIT = 2'(EXEC_CYCLES - 1);

  state_e                state_q;
  logic [1:0]            cnt_q;
  logic [8:0]            fnc_q;
  logic [NR_OF_BITS-1:0] op1_q, op2_q, res_q;
  logic [3:0]            rd_q, nzcv_q, nzcv_d;
  logic                  vld_q, wben_q, setf_q, cvupd_q;
  logic                  pass, no_wb, arith;

  alu_cond_check u_cond (
    .cond_i (bus.In_Cond),
    .nzcv_i (nzcv_q),
    .pass_o (pass)
  );

  assign no_wb  = (bus.In_Opcode inside {OP_CMP, OP_TST});
  assign arith  = (bus.In_Opcode inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB, OP_CMP});
  // Logical/shift ops only refresh N,Z; C,V survive from earlier arithmetic.
  assign nzcv_d = {bus.Flag_Out[3:2], cvupd_q ? bus.Flag_Out[1:0] : nzcv_q[1:0]};

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fnc_q   <= FNC_IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      vld_q   <= 1'b0;
      wben_q  <= 1'b0;
      setf_q  <= 1'b0;
      cvupd_q <= 1'b0;
      nzcv_q  <= STATUS_RESET;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.In_Valid) begin
          rd_q    <= bus.In_Rd;
          setf_q  <= bus.In_SetFlags || no_wb;
          cvupd_q <= arith;
          if (pass) begin
            state_q <= ST_EXEC;
            cnt_q   <= CNT_INIT;
            fnc_q   <= fnc_encode(bus.In_Opcode, nzcv_q[1]);
            op1_q   <= bus.In_Op1;
            op2_q   <= bus.In_Op2;
            wben_q  <= !no_wb;
          end else begin
            state_q <= ST_RESP;
            res_q   <= '0;
            wben_q  <= 1'b0;
            vld_q   <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (cnt_q == '0) begin
            res_q   <= bus.RESULT;
            if (setf_q) nzcv_q <= nzcv_d;
            fnc_q   <= FNC_IDLE;
            vld_q   <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ST_RESP: if (bus.Out_Ready) begin
          vld_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.In_Ready    = (state_q == ST_IDLE);
  assign bus.Fnc_SEL     = fnc_q;
  assign bus.Op1         = op1_q;
  assign bus.Op2         = op2_q;
  assign bus.Out_Valid   = vld_q;
  assign bus.Out_Result  = res_q;
  assign bus.Out_Rd      = rd_q;
  assign bus.Out_WbEn    = wben_q;
  assign bus.Status_NZCV = nzcv_q;
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a behavioural ALU and a writeback scoreboard.
module tb_alu_issue_sequencer;
  import alu_ctrl_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        wb;
    logic [3:0]  nzcv;
  } exp_t;

  logic Clock, rst_n, rst3_n;
  int   n_chk = 0, n_fail = 0;
  exp_t sb[$];
  logic [3:0] rd_tag = 4'd1;

  alu_issue_sequencer_if #(.NR_OF_BITS(32)) bus ();
  alu_issue_sequencer_if #(.NR_OF_BITS(32)) b3 ();

  alu_issue_sequencer #(.NR_OF_BITS(32), .EXEC_CYCLES(1), .STATUS_RESET(4'h0)) dut (
    .Clock(Clock), .Reset_n(rst_n), .bus(bus));
  alu_issue_sequencer #(.NR_OF_BITS(32), .EXEC_CYCLES(3), .STATUS_RESET(4'hA)) dut3 (
    .Clock(Clock), .Reset_n(rst3_n), .bus(b3));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference ALU: returns {N,Z,C,V,result}
  function automatic logic [35:0] alu_f(logic [8:0] f, logic [31:0] a, logic [31:0] b);
    logic [31:0] x, y, r;
    logic [32:0] s;
    logic c, v;
    x = f[6] ? b : a;
    y = f[6] ? a : b;
    if (f[7] | f[6]) y = ~y;
    s = {1'b0, x} + {1'b0, y} + {32'b0, f[5]};
    c = 1'b0; v = 1'b0;
    case (f[2:0])
      3'b000: begin r = s[31:0]; c = s[32]; v = (x[31] == y[31]) && (r[31] != x[31]); end
      3'b001: r = a & (f[8] ? ~b : b);
      3'b010: r = a | b;
      3'b011: r = a ^ b;
      3'b100: case (f[4:3])
                2'b00:   r = a >> b[4:0];
                2'b01:   r = $signed(a) >>> b[4:0];
                default: r = (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
              endcase
      3'b101: r = a << b[4:0];
      3'b110: r = b;
      default: r = '0;
    endcase
    return {r[31], r == 32'd0, c, v, r};
  endfunction

  assign {bus.Flag_Out, bus.RESULT} = alu_f(bus.Fnc_SEL, bus.Op1, bus.Op2);
  assign {b3.Flag_Out, b3.RESULT}   = alu_f(b3.Fnc_SEL, b3.Op1, b3.Op2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: compares each accepted writeback record
  always @(negedge Clock) begin
    if (rst_n && bus.Out_Valid && bus.Out_Ready) begin
      if (sb.size() == 0) chk("unexpected_wb", 32'(bus.Out_Rd), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("rd%0d_result", e.rd), bus.Out_Result, e.res);
        chk($sformatf("rd%0d_rd", e.rd), 32'(bus.Out_Rd), 32'(e.rd));
        chk($sformatf("rd%0d_wben", e.rd), 32'(bus.Out_WbEn), 32'(e.wb));
        chk($sformatf("rd%0d_nzcv", e.rd), 32'(bus.Status_NZCV), 32'(e.nzcv));
      end
    end
  end

  task automatic issue(input string nm, input opcode_e op, input cond_e cc, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                       input logic wb, input logic [3:0] nz, input int lat_exp,
                       input logic [8:0] fnc, input int stall = 0);
    int lat, w;
    exp_t e;
    w = 0;
    while (!bus.In_Ready && w < 50) begin @(posedge Clock); #1; w++; end
    if (w >= 50) chk({nm, "_idle_timeout"}, 32'(w), 32'd0);
    e.res = res; e.rd = rd_tag; e.wb = wb; e.nzcv = nz;
    sb.push_back(e);
    if (stall > 0) bus.Out_Ready = 1'b0;
    bus.In_Valid = 1'b1; bus.In_Opcode = op; bus.In_Cond = cc; bus.In_SetFlags = s;
    bus.In_Rd = rd_tag; bus.In_Op1 = a; bus.In_Op2 = b;
    @(posedge Clock); #1;
    bus.In_Valid = 1'b0;
    rd_tag = rd_tag + 4'd1;
    chk({nm, "_fnc"}, 32'(bus.Fnc_SEL), 32'(fnc));
    lat = 1;
    while (!bus.Out_Valid && lat < 20) begin @(posedge Clock); #1; lat++; end
    chk({nm, "_latency"}, 32'(lat), 32'(lat_exp));
    for (int i = 0; i < stall; i++) begin
      bus.In_Valid = 1'b1; bus.In_Opcode = OP_SUB; bus.In_Cond = COND_AL;
      bus.In_Op1 = 32'hDEAD; bus.In_Op2 = 32'hBEEF;
      @(posedge Clock); #1;
      chk({nm, "_stall_valid"}, 32'(bus.Out_Valid), 32'd1);
      chk({nm, "_stall_inready"}, 32'(bus.In_Ready), 32'd0);
      chk({nm, "_stall_result"}, bus.Out_Result, res);
      chk({nm, "_stall_nzcv"}, 32'(bus.Status_NZCV), 32'(nz));
    end
    bus.In_Valid = 1'b0;
    bus.Out_Ready = 1'b1;
    @(posedge Clock); #1;
    chk({nm, "_back_idle"}, {30'd0, bus.In_Ready, bus.Out_Valid}, 32'b10);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; rst3_n = 1'b0;
    bus.In_Valid = 1'b0; bus.In_Opcode = OP_ADD; bus.In_Cond = COND_AL; bus.In_SetFlags = 1'b0;
    bus.In_Rd = '0; bus.In_Op1 = '0; bus.In_Op2 = '0; bus.Out_Ready = 1'b1;
    b3.In_Valid = 1'b0; b3.In_Opcode = OP_ADD; b3.In_Cond = COND_AL; b3.In_SetFlags = 1'b0;
    b3.In_Rd = '0; b3.In_Op1 = '0; b3.In_Op2 = '0; b3.Out_Ready = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_valid", 32'(bus.Out_Valid), 32'd0);
    chk("rst_inready", 32'(bus.In_Ready), 32'd1);
    chk("rst_fnc", 32'(bus.Fnc_SEL), 32'h007);
    chk("rst_ops", bus.Op1 | bus.Op2, 32'd0);
    chk("rst_out", {bus.Out_Result[27:0], bus.Out_Rd}, 32'd0);
    chk("rst_wben", 32'(bus.Out_WbEn), 32'd0);
    chk("rst_nzcv", 32'(bus.Status_NZCV), 32'h0);
    chk("rst3_nzcv", 32'(b3.Status_NZCV), 32'hA);
    rst_n = 1'b1; rst3_n = 1'b1;
    @(posedge Clock); #1;

    //    name    op      cond     S  op1           op2          result        wb nzcv   lat fnc
    issue("add",  OP_ADD, COND_AL, 1, 5,            7,           12,           1, 4'h0,  2, 9'h000);
    issue("sub1", OP_SUB, COND_AL, 1, 3,            5,           32'hFFFFFFFE, 1, 4'h8,  2, 9'h0A0);
    issue("sub2", OP_SUB, COND_AL, 1, 5,            3,           2,            1, 4'h2,  2, 9'h0A0);
    issue("addc", OP_ADD, COND_AL, 1, 32'hFFFFFFFF, 1,           0,            1, 4'h6,  2, 9'h000);
    issue("adc1", OP_ADC, COND_AL, 0, 0,            0,           1,            1, 4'h6,  2, 9'h020);
    issue("add2", OP_ADD, COND_AL, 1, 1,            1,           2,            1, 4'h0,  2, 9'h000);
    issue("adc0", OP_ADC, COND_AL, 0, 0,            0,           0,            1, 4'h0,  2, 9'h000);
    issue("cmp",  OP_CMP, COND_AL, 0, 9,            9,           0,            0, 4'h6,  2, 9'h0A0);
    issue("moveq",OP_MOV, COND_EQ, 0, 32'h1234,     32'h55,      32'h55,       1, 4'h6,  2, 9'h006);
    issue("movne",OP_MOV, COND_NE, 1, 32'h1234,     32'h77,      0,            0, 4'h6,  1, 9'h007);
    issue("addnv",OP_ADD, COND_NV, 1, 1,            2,           0,            0, 4'h6,  1, 9'h007);
    issue("and",  OP_AND, COND_AL, 1, 32'hF0F0,     32'hFF00,    32'hF000,     1, 4'h2,  2, 9'h001);
    issue("bic",  OP_BIC, COND_AL, 0, 32'hFF,       32'h0F,      32'hF0,       1, 4'h2,  2, 9'h101);
    issue("orr",  OP_ORR, COND_AL, 0, 32'hF0,       32'h0F,      32'hFF,       1, 4'h2,  2, 9'h002);
    issue("eor",  OP_EOR, COND_AL, 0, 32'hFF,       32'h0F,      32'hF0,       1, 4'h2,  2, 9'h003);
    issue("lsl",  OP_LSL, COND_AL, 0, 1,            4,           32'h10,       1, 4'h2,  2, 9'h005);
    issue("lsr",  OP_LSR, COND_AL, 0, 32'h80000000, 4,           32'h08000000, 1, 4'h2,  2, 9'h004);
    issue("asr",  OP_ASR, COND_AL, 0, 32'h80000000, 4,           32'hF8000000, 1, 4'h2,  2, 9'h00C);
    issue("ror",  OP_ROR, COND_AL, 1, 1,            1,           32'h80000000, 1, 4'hA,  2, 9'h014);
    issue("rsb",  OP_RSB, COND_AL, 1, 3,            10,          7,            1, 4'h2,  2, 9'h060);
    issue("sbc",  OP_SBC, COND_AL, 0, 10,           3,           7,            1, 4'h2,  2, 9'h0A0);
    issue("tst",  OP_TST, COND_AL, 0, 32'h0F,       32'hF0,      0,            0, 4'h6,  2, 9'h001);
    issue("addgt",OP_ADD, COND_GT, 1, 1,            1,           0,            0, 4'h6,  1, 9'h007);
    issue("addle",OP_ADD, COND_LE, 0, 2,            2,           4,            1, 4'h6,  2, 9'h000);
    issue("addv", OP_ADD, COND_AL, 1, 32'h7FFFFFFF, 1,           32'h80000000, 1, 4'h9,  2, 9'h000);
    issue("movvs",OP_MOV, COND_VS, 0, 0,            32'h11,      32'h11,       1, 4'h9,  2, 9'h006);
    issue("movlt",OP_MOV, COND_LT, 0, 0,            32'h33,      0,            0, 4'h9,  1, 9'h007);
    issue("movge",OP_MOV, COND_GE, 0, 0,            32'h22,      32'h22,       1, 4'h9,  2, 9'h006);
    issue("stall",OP_ADD, COND_AL, 0, 2,            3,           5,            1, 4'h9,  2, 9'h000, 3);

    // EXEC_CYCLES=3 instance: latency, then reset in the middle of EXEC
    b3.In_Valid = 1'b1; b3.In_Opcode = OP_ADD; b3.In_SetFlags = 1'b1;
    b3.In_Op1 = 1; b3.In_Op2 = 1; b3.In_Rd = 4'd3;
    @(posedge Clock); #1;
    b3.In_Valid = 1'b0;
    lat = 1;
    while (!b3.Out_Valid && lat < 20) begin @(posedge Clock); #1; lat++; end
    chk("e3_latency", 32'(lat), 32'd4);
    chk("e3_result", b3.Out_Result, 32'd2);
    chk("e3_nzcv", 32'(b3.Status_NZCV), 32'h0);
    @(posedge Clock); #1;
    b3.In_Valid = 1'b1; b3.In_Op1 = 3; b3.In_Op2 = 4;
    @(posedge Clock); #1;
    b3.In_Valid = 1'b0;
    @(posedge Clock); #1;
    chk("e3_mid_fnc", 32'(b3.Fnc_SEL), 32'h000);
    chk("e3_mid_valid", 32'(b3.Out_Valid), 32'd0);
    rst3_n = 1'b0;
    #1;
    chk("e3_rst_state", {29'd0, b3.In_Ready, b3.Out_Valid, b3.Out_WbEn}, 32'b100);
    chk("e3_rst_fnc", 32'(b3.Fnc_SEL), 32'h007);
    chk("e3_rst_nzcv", 32'(b3.Status_NZCV), 32'hA);
    chk("e3_rst_ops", b3.Op1 | b3.Op2 | b3.Out_Result, 32'd0);
    @(posedge Clock); #1;
    rst3_n = 1'b1;
    repeat (6) @(posedge Clock);
    #1;
    chk("e3_after_rst", {30'd0, b3.In_Ready, b3.Out_Valid}, 32'b10);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
